mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_array.sv | 41 ++++
 rtl/mem_responder.sv | 140 ++++++++++++++
 tb/tb_mem_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: data width, parameter defaults
// and the request-tracking state encoding.
package mem_pkg;

  localparam int DATA_WIDTH         = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_LATENCY    = 5;
  localparam int COUNT_WIDTH        = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Word-addressed storage with a single write port and a registered read port.
// Contents are never cleared; only the read-data register responds to reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write port; deliberately unreset so stored words survive rst.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Read register samples the word before any same-edge write and holds it between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: accepts one read or write while idle, counts
// LATENCY cycles, then commits to the array and pulses mem_ack. A backdoor
// port can load the array at any time; a front-door write takes the single
// array write port on its commit edge.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_wr_req,
  input  logic                  mem_rd_req,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_ack,
  output logic                  mem_busy,
  input  logic                  oob_wr_en,
  input  logic [31:0]           oob_wr_addr,
  input  logic [DATA_WIDTH-1:0] oob_wr_data
);

  localparam logic [COUNT_WIDTH-1:0] CNT_INIT     = COUNT_WIDTH'(LATENCY - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE      = COUNT_WIDTH'(1);
  localparam bit                     SINGLE_CYCLE = (LATENCY == 1);

  state_e                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    wr_q;

  logic                    accept;
  logic                    commit;
  logic                    commitWr;
  logic [ADDR_WIDTH-1:0]   commitAddr;
  logic [DATA_WIDTH-1:0]   commitData;
  logic                    frontWrEn;
  logic                    arrRdEn;
  logic                    arrWrEn;
  logic [ADDR_WIDTH-1:0]   arrWrAddr;
  logic [DATA_WIDTH-1:0]   arrWrData;
  logic                    unused_upper_bits;

  // Upper address bits are not decoded, so addresses wrap inside the array.
  assign unused_upper_bits = ^{mem_addr[31:ADDR_WIDTH], oob_wr_addr[31:ADDR_WIDTH]};

  assign accept = (state_q == ST_IDLE) && (mem_rd_req || mem_wr_req);

  // The commit edge is the one entering the ack cycle; with a latency of one that
  // is the accepting edge itself, so the live inputs are used instead of the latches.
  assign commit     = !rst && (((state_q == ST_WAIT) && (cnt_q == CNT_ONE)) ||
                               (SINGLE_CYCLE && accept));
  assign commitWr   = (state_q == ST_IDLE) ? mem_wr_req : wr_q;
  assign commitAddr = (state_q == ST_IDLE) ? mem_addr[ADDR_WIDTH-1:0] : addr_q;
  assign commitData = (state_q == ST_IDLE) ? mem_wr_data : wdata_q;

  assign frontWrEn = commit && commitWr;
  assign arrRdEn   = commit && !commitWr;

  // Front-door write owns the write port on its commit edge; otherwise the backdoor uses it.
  assign arrWrEn   = frontWrEn || oob_wr_en;
  assign arrWrAddr = frontWrEn ? commitAddr : oob_wr_addr[ADDR_WIDTH-1:0];
  assign arrWrData = frontWrEn ? commitData : oob_wr_data;

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: idle until a request, then count down and leave after the ack cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: busy while counting, ack once the count has run out.
  always_comb begin
    mem_ack  = 1'b0;
    mem_busy = 1'b0;
    if (state_q == ST_WAIT) begin
      mem_ack  = (cnt_q == '0);
      mem_busy = (cnt_q != '0);
    end
  end

  // Capture the accepted request; requests arriving in WAIT never reach here.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= mem_addr[ADDR_WIDTH-1:0];
      wdata_q <= mem_wr_data;
      wr_q    <= mem_wr_req;
    end
  end

  mem_array #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (arrWrEn),
    .wr_addr_i (arrWrAddr),
    .wr_data_i (arrWrData),
    .rd_en_i   (arrRdEn),
    .rd_addr_i (commitAddr),
    .rd_data_o (mem_rd_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench: directed scenarios plus randomized transactions against a
// transaction-level memory model; a second instance covers the LATENCY=1 build.
module tb_mem_responder;

  localparam int LAT = 5;
  localparam int AW  = 10;

  logic        clk;
  logic        rst;
  logic [31:0] memAddr, memWrData, memRdData;
  logic        memWrReq, memRdReq, memAck, memBusy;
  logic        oobWrEn;
  logic [31:0] oobWrAddr, oobWrData;

  logic [31:0] addr1, wrData1, rdData1;
  logic        wrReq1, rdReq1, ack1, busy1;

  logic [31:0] model [1 << AW];
  logic [31:0] lastRd;
  int          testCount;
  int          failCount;

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (memAddr),
    .mem_wr_data (memWrData),
    .mem_wr_req  (memWrReq),
    .mem_rd_req  (memRdReq),
    .mem_rd_data (memRdData),
    .mem_ack     (memAck),
    .mem_busy    (memBusy),
    .oob_wr_en   (oobWrEn),
    .oob_wr_addr (oobWrAddr),
    .oob_wr_data (oobWrData)
  );

  mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .mem_addr    (addr1),
    .mem_wr_data (wrData1),
    .mem_wr_req  (wrReq1),
    .mem_rd_req  (rdReq1),
    .mem_rd_data (rdData1),
    .mem_ack     (ack1),
    .mem_busy    (busy1),
    .oob_wr_en   (oobWrEn),
    .oob_wr_addr (oobWrAddr),
    .oob_wr_data (oobWrData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    memRdReq  = 1'b0;
    memWrReq  = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    oobWrEn   = 1'b0;
    oobWrAddr = '0;
    oobWrData = '0;
  endtask

  // One transaction on the LATENCY=5 instance, starting in the cycle it is called.
  // kind: 0 read, 1 write, 2 read+write. dropAt/oobAt are cycle offsets (-1 = none).
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] data,
                               input int dropAt, input logic dropWr, input logic [31:0] dropAddr,
                               input int oobAt, input logic [31:0] oobAddr, input logic [31:0] oobData);
    logic [31:0] expRd;
    logic [AW-1:0] a;
    a = addr[AW-1:0];
    expRd = '0;
    for (int o = 0; o <= LAT; o++) begin
      memRdReq  = 1'b0;
      memWrReq  = 1'b0;
      memAddr   = $urandom;
      memWrData = $urandom;
      oobWrEn   = 1'b0;
      oobWrAddr = $urandom;
      oobWrData = $urandom;
      if (o == 0) begin
        memRdReq  = (kind != 1);
        memWrReq  = (kind != 0);
        memAddr   = addr;
        memWrData = data;
      end else if (o == dropAt) begin
        memRdReq = !dropWr;
        memWrReq = dropWr;
        memAddr  = dropAddr;
      end
      if (o == oobAt) begin
        oobWrEn   = 1'b1;
        oobWrAddr = oobAddr;
        oobWrData = oobData;
      end
      if (o == 0) begin
        checkOutput("idle_ack", {31'b0, memAck}, 32'd0);
        checkOutput("idle_busy", {31'b0, memBusy}, 32'd0);
        checkOutput("rd_hold", memRdData, lastRd);
      end else if (o < LAT) begin
        checkOutput("wait_busy", {31'b0, memBusy}, 32'd1);
        checkOutput("wait_ack", {31'b0, memAck}, 32'd0);
      end else begin
        checkOutput("ack_pulse", {31'b0, memAck}, 32'd1);
        checkOutput("ack_busy", {31'b0, memBusy}, 32'd0);
        if (kind == 0) checkOutput("rd_data", memRdData, expRd);
      end
      // Model the edge closing this cycle: read sees the old word, backdoor lands,
      // then a front-door write overrides anything on the same word.
      if (o == LAT - 1 && kind == 0) expRd = model[a];
      if (o == oobAt) model[oobAddr[AW-1:0]] = oobData;
      if (o == LAT - 1 && kind != 0) model[a] = data;
      tick();
    end
    if (kind == 0) lastRd = expRd;
    clearInputs();
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] old9;
    logic [31:0] a;
    int kind, dropAt, oobAt;
    logic dropWr;
    testCount = 0;
    failCount = 0;
    lastRd    = '0;
    clearInputs();
    addr1   = '0;
    wrData1 = '0;
    wrReq1  = 1'b0;
    rdReq1  = 1'b0;
    rst     = 1'b1;
    repeat (2) tick();

    checkOutput("rst_ack", {31'b0, memAck}, 32'd0);
    checkOutput("rst_busy", {31'b0, memBusy}, 32'd0);
    checkOutput("rst_rd_data", memRdData, 32'd0);
    checkOutput("rst_ack_l1", {31'b0, ack1}, 32'd0);
    checkOutput("rst_rd_data_l1", rdData1, 32'd0);

    // Load every word through the backdoor while still in reset, with junk upper address bits.
    for (int i = 0; i < (1 << AW); i++) begin
      word      = $urandom;
      oobWrEn   = 1'b1;
      oobWrAddr = ($urandom << AW) | 32'(i);
      oobWrData = word;
      model[i]  = word;
      tick();
    end
    clearInputs();
    checkOutput("rst_load_busy", {31'b0, memBusy}, 32'd0);
    rst = 1'b0;
    tick();

    // LATENCY=1 instance: read every other cycle; ack follows each, busy never rises.
    for (int k = 0; k < 10; k++) begin
      rdReq1 = 1'b1;
      addr1  = $urandom;
      word   = model[addr1[AW-1:0]];
      checkOutput("l1_req_ack", {31'b0, ack1}, 32'd0);
      checkOutput("l1_req_busy", {31'b0, busy1}, 32'd0);
      tick();
      rdReq1 = 1'b0;
      checkOutput("l1_ack", {31'b0, ack1}, 32'd1);
      checkOutput("l1_ack_busy", {31'b0, busy1}, 32'd0);
      checkOutput("l1_rd_data", rdData1, word);
      tick();
    end

    // Backdoor word then front-door read of it.
    oobWrEn   = 1'b1;
    oobWrAddr = 32'd3;
    oobWrData = 32'hDEADBEEF;
    model[3]  = 32'hDEADBEEF;
    tick();
    clearInputs();
    applyStimulus(0, 32'd3, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("deadbeef", lastRd, 32'hDEADBEEF);

    // Write then back-to-back read in the cycle after the ack.
    applyStimulus(1, 32'd7, 32'h12345678, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    applyStimulus(0, 32'd7, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("wr_then_rd", lastRd, 32'h12345678);

    // Write to the same word arriving mid-read is dropped.
    word = model[2];
    applyStimulus(0, 32'd2, 32'd0, 2, 1'b1, 32'd2, -1, 32'd0, 32'd0);
    applyStimulus(0, 32'd2, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("dropped_wr", lastRd, word);

    // Simultaneous read and write is a write; address wraps to word 5.
    applyStimulus(2, 32'h405, 32'hA5, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    applyStimulus(0, 32'd5, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("both_is_wr", lastRd, 32'hA5);

    // Front-door write beats a backdoor write to the same word on the commit edge.
    applyStimulus(1, 32'd11, 32'hAAAA0001, -1, 1'b0, 32'd0, LAT - 1, 32'd11, 32'h5555FFFE);
    applyStimulus(0, 32'd11, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("front_wins", lastRd, 32'hAAAA0001);

    // Reset during an in-flight write aborts it.
    old9      = model[9];
    memWrReq  = 1'b1;
    memAddr   = 32'd9;
    memWrData = 32'h1;
    tick();
    clearInputs();
    repeat (2) begin
      checkOutput("abort_busy_pre", {31'b0, memBusy}, 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst    = 1'b0;
    lastRd = '0;
    checkOutput("abort_busy", {31'b0, memBusy}, 32'd0);
    checkOutput("abort_rd_data", memRdData, 32'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("abort_no_ack", {31'b0, memAck}, 32'd0);
      tick();
    end
    applyStimulus(0, 32'd9, 32'd0, -1, 1'b0, 32'd0, -1, 32'd0, 32'd0);
    checkOutput("abort_old_value", lastRd, old9);

    // Randomized traffic with dropped requests and backdoor writes before the commit edge.
    for (int n = 0; n < 60; n++) begin
      kind   = int'($urandom_range(0, 2));
      a      = $urandom;
      dropAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, LAT)) : -1;
      dropWr = 1'($urandom_range(0, 1));
      oobAt  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, LAT - 2)) : -1;
      word   = ($urandom_range(0, 1) == 1) ? a : $urandom;
      applyStimulus(kind, a, $urandom, dropAt, dropWr, $urandom, oobAt, word, $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
